// File: rtl/irq_pending_ctrl.sv
// Interrupt capture: synchronise request lines, latch rising edges into pending,
// and hold a masked snapshot for the priority encoder until the serviced index is acked.
module irq_pending_ctrl #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    irq_in,
  input  logic [N-1:0]    mask,
  input  logic            glb_en,
  input  logic            ack,
  input  logic [ID_W-1:0] ack_id,
  input  logic            clr_lost,
  output logic [N-1:0]    req_vec,
  output logic            req_en,
  output logic            irq_valid,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    lost
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sync_q [SYNC_STAGES];
  logic [N-1:0]   prev_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   req_vec_nxt;
  logic           irq_valid_nxt;
  logic           ack_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign ack_take = (state == HOLD) && ack;

  // An out-of-range ack_id matches no bit, so it behaves like acking an empty line.
  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < N; k++) begin
      if (ack_take && (ack_id == ID_W'(k))) clr_vec[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      lost    <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | rise;
      lost    <= (clr_lost ? '0 : lost) | (rise & pending & ~clr_vec);
    end
  end

  always_comb begin
    state_nxt     = state;
    req_vec_nxt   = req_vec;
    irq_valid_nxt = irq_valid;
    case (state)
      IDLE: begin
        if (glb_en && ((pending & mask) != '0)) begin
          state_nxt     = HOLD;
          req_vec_nxt   = pending & mask;
          irq_valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (ack) begin
          state_nxt     = IDLE;
          req_vec_nxt   = '0;
          irq_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_vec_nxt   = '0;
        irq_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_vec   <= '0;
      irq_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_vec   <= req_vec_nxt;
      irq_valid <= irq_valid_nxt;
    end
  end

  assign req_en = irq_valid;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed latency/reset scenarios plus randomized traffic
// compared every cycle against a behavioural model of the pending/snapshot rules.
module tb_irq_pending_ctrl;
  localparam int N = 8;
  localparam int S = 2;
  localparam int ID_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    irq_in = '0;
  logic [N-1:0]    mask = '1;
  logic            glb_en = 1'b1;
  logic            ack = 1'b0;
  logic [ID_W-1:0] ack_id = '0;
  logic            clr_lost = 1'b0;
  logic [N-1:0]    req_vec, pending, lost;
  logic            req_en, irq_valid;

  irq_pending_ctrl #(.N(N), .SYNC_STAGES(S), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .glb_en(glb_en),
    .ack(ack), .ack_id(ack_id), .clr_lost(clr_lost), .req_vec(req_vec),
    .req_en(req_en), .irq_valid(irq_valid), .pending(pending), .lost(lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a line's synchronised level is its irq_in sample from S-1 edges
  // ago; a new event is a 0->1 step of that level between consecutive edges.
  logic [N-1:0] samples [$];
  logic [N-1:0] m_pend, m_lost, m_snap;
  logic         m_valid;

  function automatic logic [N-1:0] level_ago(input int d);
    return (samples.size() > d) ? samples[samples.size()-1-d] : '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      samples.delete();
      m_pend = '0; m_lost = '0; m_snap = '0; m_valid = 1'b0;
    end else begin
      logic [N-1:0] ev, clr, pend_old;
      ev = level_ago(S-1) & ~level_ago(S);
      samples.push_back(irq_in);
      if (samples.size() > S + 2) void'(samples.pop_front());
      clr = '0;
      if (m_valid && ack && int'(ack_id) < N) clr[ack_id] = 1'b1;
      pend_old = m_pend;
      m_lost = (clr_lost ? '0 : m_lost) | (ev & pend_old & ~clr);
      m_pend = (pend_old & ~clr) | ev;
      if (m_valid) begin
        if (ack) begin m_valid = 1'b0; m_snap = '0; end
      end else if (glb_en && (pend_old & mask) != '0) begin
        m_valid = 1'b1; m_snap = pend_old & mask;
      end
    end
  end

  bit model_chk = 1'b0;
  always @(negedge clk) begin
    if (model_chk) begin
      check("m_req_vec", req_vec, m_snap);
      check("m_irq_valid", irq_valid, m_valid);
      check("m_req_en", req_en, m_valid);
      check("m_pending", pending, m_pend);
      check("m_lost", lost, m_lost);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_req_vec", req_vec, 0);
    check("rst_valid", irq_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_lost", lost, 0);
    model_chk = 1'b1;

    // Single request latency: pending after edge 3, valid after edge 4
    @(negedge clk);
    irq_in = 8'h10;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("single_pend_e3", pending, 8'h10);
    check("single_valid_e3", irq_valid, 0);
    @(posedge clk);
    #1 check("single_valid_e4", irq_valid, 1);
    check("single_vec_e4", req_vec, 8'h10);
    @(negedge clk);
    ack = 1'b1; ack_id = 3'd4; irq_in = '0;
    @(negedge clk);
    ack = 1'b0;
    check("single_ack_pend", pending, 0);
    check("single_ack_valid", irq_valid, 0);

    // Set/clear collision on line 3, then lost
    irq_in = 8'h08;
    cyc(4);
    check("coll_hold", req_vec, 8'h08);
    irq_in = 8'h00;
    cyc(2);
    irq_in = 8'h08;
    cyc(2);
    ack = 1'b1; ack_id = 3'd3;
    @(negedge clk);
    ack = 1'b0;
    check("coll_pend", pending, 8'h08);
    check("coll_lost", lost, 8'h00);
    glb_en = 1'b0;
    irq_in = 8'h00;
    cyc(2);
    irq_in = 8'h08;
    cyc(4);
    check("lost_set", lost, 8'h08);
    clr_lost = 1'b1;
    @(negedge clk);
    clr_lost = 1'b0;
    check("lost_clr", lost, 8'h00);
    glb_en = 1'b1;
    ack = 1'b1; ack_id = 3'd5;
    cyc(2);
    ack = 1'b0;
    check("badid_pend", pending, 8'h08);

    // Async reset mid-HOLD, line 7 held high across reset
    irq_in = 8'h80;
    cyc(6);
    check("pre_rst_valid", irq_valid, 1);
    #2 rst = 1'b1;
    #1 check("arst_valid", irq_valid, 0);
    check("arst_vec", req_vec, 0);
    check("arst_pend", pending, 0);
    check("arst_lost", lost, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rerst_pend_e3", pending, 8'h80);
    @(posedge clk);
    #1 check("rerst_valid_e4", irq_valid, 1);
    check("rerst_vec_e4", req_vec, 8'h80);

    // Randomized traffic against the model
    @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 30) == 0) mask = N'($urandom);
      glb_en   = ($urandom_range(0, 9) != 0);
      clr_lost = ($urandom_range(0, 19) == 0);
      ack      = irq_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      ack_id   = ID_W'($urandom);
      if (irq_valid && $urandom_range(0, 3) != 0) begin
        for (int b = N - 1; b >= 0; b--) if (req_vec[b]) ack_id = ID_W'(b);
      end
      @(negedge clk);
    end
    model_chk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
